// File: rtl/reset_request_gen.sv
// System-reset request generator: watchdog and keyed software sources,
// fixed-width reset_req pulse, sticky cause and post-pulse hold-off.
module reset_request_gen #(
   parameter int                   WDT_WIDTH      = 24,
   parameter logic [WDT_WIDTH-1:0] WDT_TIMEOUT    = 24'hFFFFFF,
   parameter int                   PULSE_CYCLES   = 32,
   parameter int                   HOLDOFF_CYCLES = 8,
   parameter logic [7:0]           SW_KEY         = 8'hA5
) (
   input  logic                 clk_0,
   input  logic                 por_reset,
   input  logic                 wdt_enable,
   input  logic                 wdt_kick,
   input  logic                 sw_req,
   input  logic [7:0]           sw_key,
   input  logic                 cause_clear,
   output logic                 reset_req,
   output logic [1:0]           reset_cause,
   output logic [WDT_WIDTH-1:0] wdt_count,
   output logic                 busy
);

   localparam int CNT_MAX = (PULSE_CYCLES > HOLDOFF_CYCLES) ?
                            PULSE_CYCLES : HOLDOFF_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ASSERT  = 2'd1,
      HOLDOFF = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [CNT_W-1:0]     r_cnt;
   logic [CNT_W-1:0]     w_cnt_nxt;
   logic [WDT_WIDTH-1:0] r_wdt;
   logic [WDT_WIDTH-1:0] w_wdt_nxt;
   logic [1:0]           r_cause;
   logic [1:0]           w_cause_nxt;
   logic                 r_req;
   logic                 r_busy;
   logic                 w_idle;
   logic                 w_wdt_fire;
   logic                 w_sw_fire;
   logic                 w_fire;

   // Sources only count while idle; anything during a pulse or hold-off is dropped
   assign w_idle     = (r_state == IDLE);
   assign w_wdt_fire = w_idle & wdt_enable & ~wdt_kick &
                       (r_wdt == '0);
   assign w_sw_fire  = w_idle & sw_req & (sw_key == SW_KEY);
   assign w_fire     = w_wdt_fire | w_sw_fire;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_wdt_nxt   = r_wdt;
      w_cause_nxt = r_cause;
      unique case (r_state)
         IDLE: begin
            if (w_fire) begin
               w_state_nxt = ASSERT;
               w_cnt_nxt   = CNT_W'(PULSE_CYCLES - 1);
               w_wdt_nxt   = WDT_TIMEOUT;
            end else if (!wdt_enable || wdt_kick) begin
               w_wdt_nxt = WDT_TIMEOUT;
            end else if (r_wdt != '0) begin
               w_wdt_nxt = r_wdt - 1'b1;
            end
         end
         ASSERT: begin
            w_wdt_nxt = WDT_TIMEOUT;
            if (r_cnt == '0) begin
               w_state_nxt = HOLDOFF;
               w_cnt_nxt   = CNT_W'(HOLDOFF_CYCLES - 1);
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         HOLDOFF: begin
            w_wdt_nxt = WDT_TIMEOUT;
            if (r_cnt == '0) begin
               w_state_nxt = IDLE;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_wdt_nxt   = WDT_TIMEOUT;
         end
      endcase
      // A new fire takes priority over a clear in the same cycle
      if (w_fire) begin
         w_cause_nxt = {w_sw_fire, w_wdt_fire};
      end else if (cause_clear) begin
         w_cause_nxt = 2'b00;
      end
   end

   always_ff @(posedge clk_0 or posedge por_reset) begin
      if (por_reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_wdt   <= WDT_TIMEOUT;
         r_cause <= 2'b00;
         r_req   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_wdt   <= w_wdt_nxt;
         r_cause <= w_cause_nxt;
         r_req   <= (w_state_nxt == ASSERT);
         r_busy  <= (w_state_nxt != IDLE);
      end
   end

   assign reset_req   = r_req;
   assign reset_cause = r_cause;
   assign wdt_count   = r_wdt;
   assign busy        = r_busy;

endmodule

// File: tb/tb_reset_request_gen.sv
// Directed bench for reset_request_gen with a short watchdog timeout.
module tb_reset_request_gen;

   localparam int W     = 24;
   localparam int PULSE = 32;
   localparam int HOLD  = 8;

   logic         clk_0;
   logic         por_reset;
   logic         wdt_enable;
   logic         wdt_kick;
   logic         sw_req;
   logic [7:0]   sw_key;
   logic         cause_clear;
   logic         reset_req;
   logic [1:0]   reset_cause;
   logic [W-1:0] wdt_count;
   logic         busy;

   int checks = 0;
   int errors = 0;

   reset_request_gen #(
      .WDT_WIDTH      (W),
      .WDT_TIMEOUT    (24'd10),
      .PULSE_CYCLES   (PULSE),
      .HOLDOFF_CYCLES (HOLD),
      .SW_KEY         (8'hA5)
   ) dut (
      .clk_0       (clk_0),
      .por_reset   (por_reset),
      .wdt_enable  (wdt_enable),
      .wdt_kick    (wdt_kick),
      .sw_req      (sw_req),
      .sw_key      (sw_key),
      .cause_clear (cause_clear),
      .reset_req   (reset_req),
      .reset_cause (reset_cause),
      .wdt_count   (wdt_count),
      .busy        (busy)
   );

   initial begin
      clk_0 = 1'b0;
      forever #5 clk_0 = ~clk_0;
   end

   task automatic step();
      @(posedge clk_0);
      #1;
   endtask

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at the first reset_req-high cycle; ends at the first idle cycle
   task automatic pulse_and_holdoff(input string tag);
      for (int i = 0; i < PULSE; i++) begin
         check({tag, "_req_hi"}, 32'(reset_req), 32'd1);
         check({tag, "_busy_a"}, 32'(busy), 32'd1);
         step();
      end
      for (int i = 0; i < HOLD; i++) begin
         check({tag, "_req_lo"}, 32'(reset_req), 32'd0);
         check({tag, "_busy_h"}, 32'(busy), 32'd1);
         step();
      end
      check({tag, "_busy_end"}, 32'(busy), 32'd0);
      check({tag, "_req_end"}, 32'(reset_req), 32'd0);
   endtask

   initial begin
      por_reset   = 1'b1;
      wdt_enable  = 1'b0;
      wdt_kick    = 1'b0;
      sw_req      = 1'b0;
      sw_key      = 8'h00;
      cause_clear = 1'b0;
      #2;
      check("rst_req", 32'(reset_req), 32'd0);
      check("rst_cause", 32'(reset_cause), 32'd0);
      check("rst_wdt", 32'(wdt_count), 32'd10);
      check("rst_busy", 32'(busy), 32'd0);
      step();
      step();
      por_reset = 1'b0;

      // 1: watchdog timeout
      wdt_enable = 1'b1;
      check("t1_wdt_c0", 32'(wdt_count), 32'd10);
      for (int i = 0; i < 10; i++) step();
      check("t1_wdt_c10", 32'(wdt_count), 32'd0);
      check("t1_req_c10", 32'(reset_req), 32'd0);
      step();
      wdt_enable = 1'b0;
      check("t1_cause", 32'(reset_cause), 32'd1);
      check("t1_wdt_hold", 32'(wdt_count), 32'd10);
      pulse_and_holdoff("t1");

      // 2: regular kicks keep the watchdog from firing
      cause_clear = 1'b1;
      step();
      cause_clear = 1'b0;
      check("t2_clear", 32'(reset_cause), 32'd0);
      wdt_enable = 1'b1;
      for (int i = 0; i < 200; i++) begin
         wdt_kick = (i % 8 == 0);
         step();
         check("t2_req", 32'(reset_req), 32'd0);
         check("t2_min", 32'(wdt_count >= 24'd2), 32'd1);
      end
      wdt_kick   = 1'b0;
      wdt_enable = 1'b0;
      step();
      check("t2_reload", 32'(wdt_count), 32'd10);

      // 3: software requests, good key then bad key
      sw_req = 1'b1;
      sw_key = 8'hA5;
      step();
      sw_req = 1'b0;
      check("t3_cause", 32'(reset_cause), 32'd2);
      pulse_and_holdoff("t3");
      sw_req = 1'b1;
      sw_key = 8'h5A;
      step();
      sw_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("t3_badkey_req", 32'(reset_req), 32'd0);
         check("t3_badkey_busy", 32'(busy), 32'd0);
         step();
      end
      check("t3_badkey_cause", 32'(reset_cause), 32'd2);

      // 4: simultaneous sources, and clear losing to a fire
      cause_clear = 1'b1;
      step();
      cause_clear = 1'b0;
      check("t4_clear", 32'(reset_cause), 32'd0);
      wdt_enable = 1'b1;
      for (int i = 0; i < 10; i++) step();
      check("t4_wdt0", 32'(wdt_count), 32'd0);
      sw_req = 1'b1;
      sw_key = 8'hA5;
      step();
      sw_req     = 1'b0;
      wdt_enable = 1'b0;
      check("t4_both", 32'(reset_cause), 32'd3);
      pulse_and_holdoff("t4a");
      cause_clear = 1'b1;
      sw_req      = 1'b1;
      step();
      cause_clear = 1'b0;
      sw_req      = 1'b0;
      check("t4_fire_wins", 32'(reset_cause), 32'd2);
      pulse_and_holdoff("t4b");

      // 5: requests while busy are dropped; first idle cycle accepts
      sw_req = 1'b1;
      step();
      sw_req = 1'b0;
      for (int i = 0; i < PULSE; i++) begin
         check("t5_req_hi", 32'(reset_req), 32'd1);
         if (i == 5) begin
            sw_req      = 1'b1;
            cause_clear = 1'b1;
         end
         step();
         sw_req      = 1'b0;
         cause_clear = 1'b0;
      end
      check("t5_clear_busy", 32'(reset_cause), 32'd0);
      for (int i = 0; i < HOLD; i++) begin
         check("t5_hold", 32'(busy), 32'd1);
         if (i == HOLD - 1) sw_req = 1'b1;
         step();
         sw_req = 1'b0;
      end
      check("t5_last_hold_req", 32'(reset_req), 32'd0);
      check("t5_last_hold_busy", 32'(busy), 32'd0);
      check("t5_last_hold_cause", 32'(reset_cause), 32'd0);
      sw_req = 1'b1;
      step();
      sw_req = 1'b0;
      check("t5_accept_cause", 32'(reset_cause), 32'd2);
      pulse_and_holdoff("t5");

      // 6: power-on reset in the middle of a pulse
      sw_req = 1'b1;
      step();
      sw_req = 1'b0;
      for (int i = 0; i < 14; i++) step();
      check("t6_pre_req", 32'(reset_req), 32'd1);
      check("t6_pre_cause", 32'(reset_cause), 32'd2);
      #2;
      por_reset = 1'b1;
      #1;
      check("t6_async_req", 32'(reset_req), 32'd0);
      check("t6_async_cause", 32'(reset_cause), 32'd0);
      check("t6_async_wdt", 32'(wdt_count), 32'd10);
      check("t6_async_busy", 32'(busy), 32'd0);
      step();
      por_reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check("t6_idle_req", 32'(reset_req), 32'd0);
         check("t6_idle_busy", 32'(busy), 32'd0);
         check("t6_idle_wdt", 32'(wdt_count), 32'd10);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
